// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for a small 6-bit address / 10-bit instruction core.
// Keeps the program counter, drives the program ROM address, and captures the
// returned word into the instruction register.
//
// Behaviour in RUN, highest priority first:
//   - redirect: load BR_TARGET into the PC and insert a bubble
//   - halt: enter HALT and insert a bubble
//   - stall: hold everything
//   - fetch: capture the ROM word and advance the PC
// HALT is left only through reset.
//
// Ports
//   CLK        in   1       clock, rising edge
//   RST_N      in   1       asynchronous active-low reset
//   STALL      in   1       downstream cannot accept an instruction
//   BR_TAKEN   in   1       redirect fetch this cycle
//   BR_TARGET  in   ADDR_W  redirect address
//   HALT_REQ   in   1       request to stop fetching
//   Q          in   DATA_W  ROM data for address AD (combinational)
//   AD         out  ADDR_W  ROM address (current PC)
//   IR         out  DATA_W  instruction register {opcode, operand}
//   IR_PC      out  ADDR_W  address the IR word came from
//   IR_VALID   out  1       IR holds a real fetched instruction
//   HALTED     out  1       block is in HALT
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic              HALT_REQ,
  input  logic [DATA_W-1:0] Q,
  output logic [ADDR_W-1:0] AD,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_VALID,
  output logic              HALTED
);

  // All-zero word (opcode 0000) is the single bubble encoding.
  localparam logic [DATA_W-1:0] NOP = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      pc       <= '0;
      IR       <= NOP;
      IR_PC    <= '0;
      IR_VALID <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (BR_TAKEN) begin
            // Word on Q belongs to the wrong path; drop it. A concurrent
            // HALT_REQ is deliberately not taken on this edge.
            pc       <= BR_TARGET;
            IR       <= NOP;
            IR_PC    <= pc;
            IR_VALID <= 1'b0;
          end else if (HALT_REQ) begin
            state    <= HALT;
            IR       <= NOP;
            IR_VALID <= 1'b0;
          end else if (!STALL) begin
            // PC wraps modulo 2**ADDR_W by natural overflow.
            pc       <= pc + ADDR_W'(1);
            IR       <= Q;
            IR_PC    <= pc;
            IR_VALID <= 1'b1;
          end
        end
        default: begin
          // HALT: everything holds, all requests ignored.
        end
      endcase
    end
  end

  assign AD     = pc;
  assign HALTED = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       CLK;
  logic       RST_N;
  logic       STALL;
  logic       BR_TAKEN;
  logic [5:0] BR_TARGET;
  logic       HALT_REQ;
  logic [9:0] Q;
  logic [5:0] AD;
  logic [9:0] IR;
  logic [5:0] IR_PC;
  logic       IR_VALID;
  logic       HALTED;

  int checks = 0;
  int errors = 0;

  logic [9:0] rom [64];

  fetch_unit dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .STALL    (STALL),
    .BR_TAKEN (BR_TAKEN),
    .BR_TARGET(BR_TARGET),
    .HALT_REQ (HALT_REQ),
    .Q        (Q),
    .AD       (AD),
    .IR       (IR),
    .IR_PC    (IR_PC),
    .IR_VALID (IR_VALID),
    .HALTED   (HALTED)
  );

  // Zero-latency ROM
  assign Q = rom[AD];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       stall;
    logic       br;
    logic [5:0] tgt;
    logic       halt;
    logic [5:0] ad;
    logic [5:0] irpc;
    logic       vld;
    logic       h;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic stall, logic br, logic [5:0] tgt, logic halt,
                              logic [5:0] ad, logic [5:0] irpc, logic vld, logic h);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.halt = halt;
    v.ad = ad; v.irpc = irpc; v.vld = vld; v.h = h;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A valid IR must equal the ROM word at IR_PC; a bubble is always zero.
  task automatic cmp(string tag, vec_t e);
    logic [9:0] exp_ir;
    exp_ir = e.vld ? rom[e.irpc] : 10'h000;
    chk({tag, ".AD"},       32'(AD),       32'(e.ad));
    chk({tag, ".IR"},       32'(IR),       32'(exp_ir));
    chk({tag, ".IR_PC"},    32'(IR_PC),    32'(e.irpc));
    chk({tag, ".IR_VALID"}, 32'(IR_VALID), 32'(e.vld));
    chk({tag, ".HALTED"},   32'(HALTED),   32'(e.h));
  endtask

  task automatic chk_reset_state(string tag);
    cmp(tag, mk(0, 0, 0, 0, 6'd0, 6'd0, 1'b0, 1'b0));
  endtask

  // Drive one vector at the falling edge, push its expectation, let one rising
  // edge pass, then pop and compare at the next falling edge.
  task automatic apply(string tag, vec_t v);
    vec_t e;
    STALL     = v.stall;
    BR_TAKEN  = v.br;
    BR_TARGET = v.tgt;
    HALT_REQ  = v.halt;
    sb.push_back(v);
    @(posedge CLK);
    @(negedge CLK);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      cmp(tag, e);
    end
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic async_reset(string tag);
    #3;
    RST_N = 1'b0;
    #1;
    chk_reset_state(tag);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = {4'(i * 3 + 1), 6'(i) ^ 6'h2A};
    rom[0] = 10'h13C;
    rom[1] = 10'h280;

    RST_N = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0; HALT_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_state("rst");
    RST_N = 1'b1;

    //           stall br tgt  halt  ad   irpc vld h
    tbl.push_back(mk(0, 0, 0,  0,    1,   0,   1,  0)); // fetch q[0]=0x13C
    tbl.push_back(mk(0, 0, 0,  0,    2,   1,   1,  0)); // fetch q[1]=0x280
    tbl.push_back(mk(0, 0, 0,  0,    3,   2,   1,  0));
    tbl.push_back(mk(0, 0, 0,  0,    4,   3,   1,  0));
    tbl.push_back(mk(1, 0, 0,  0,    4,   3,   1,  0)); // stall x3 at PC=4
    tbl.push_back(mk(1, 0, 0,  0,    4,   3,   1,  0));
    tbl.push_back(mk(1, 0, 0,  0,    4,   3,   1,  0));
    tbl.push_back(mk(0, 0, 0,  0,    5,   4,   1,  0)); // resume at 4
    tbl.push_back(mk(1, 1, 9,  0,    9,   5,   0,  0)); // redirect during stall
    tbl.push_back(mk(0, 0, 0,  0,   10,   9,   1,  0)); // q[9]
    tbl.push_back(mk(0, 1, 63, 0,   63,  10,   0,  0)); // jump to 63
    tbl.push_back(mk(0, 0, 0,  0,    0,  63,   1,  0)); // wrap
    tbl.push_back(mk(0, 0, 0,  0,    1,   0,   1,  0));
    tbl.push_back(mk(0, 1, 1,  0,    1,   1,   0,  0)); // self-loop
    tbl.push_back(mk(0, 0, 0,  0,    2,   1,   1,  0));
    tbl.push_back(mk(0, 1, 30, 1,   30,   2,   0,  0)); // branch beats halt
    tbl.push_back(mk(0, 0, 0,  1,   30,   2,   0,  1)); // halt taken
    tbl.push_back(mk(1, 1, 5,  0,   30,   2,   0,  1)); // ignored in HALT
    tbl.push_back(mk(0, 0, 0,  0,   30,   2,   0,  1));
    tbl.push_back(mk(0, 0, 0,  1,   30,   2,   0,  1));

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    async_reset("rst_in_halt");

    // Halt at PC=8, then ten edges of ignored requests.
    apply("to8",   mk(0, 1, 8, 0,  8, 0, 0, 0));
    apply("halt8", mk(0, 0, 0, 1,  8, 0, 0, 1));
    for (int k = 0; k < 10; k++)
      apply($sformatf("hold%0d", k), mk(k[1], ~k[0], 6'd3, k[2], 8, 0, 0, 1));
    async_reset("rst_after_halt8");

    // Reset while stalled, then first edge fetches address 0.
    apply("f0", mk(0, 0, 0, 0, 1, 0, 1, 0));
    apply("f1", mk(0, 0, 0, 0, 2, 1, 1, 0));
    apply("f2", mk(0, 0, 0, 0, 3, 2, 1, 0));
    apply("st", mk(1, 0, 0, 0, 3, 2, 1, 0));
    async_reset("rst_in_stall");
    apply("post_rst", mk(0, 0, 0, 0, 1, 0, 1, 0));

    // Halt outranks stall.
    apply("halt_stall", mk(1, 0, 0, 1, 1, 0, 0, 1));

    // Redirect held during reset has no effect.
    STALL = 1'b0; HALT_REQ = 1'b0; BR_TAKEN = 1'b1; BR_TARGET = 6'd20;
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_state("rst_with_br");
    BR_TAKEN = 1'b0;
    RST_N = 1'b1;
    apply("post_rst_br", mk(0, 0, 0, 0, 1, 0, 1, 0));

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
